uart_bus_arbiter: RTL and testbench

UART_BUS_ARBITER -- requirements
Module: uart_bus_arbiter

---
 rtl/uart_bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_uart_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_arbiter.sv
// Two-master round-robin arbiter in front of a UART register bank (Idle/Issue/Wait/Done).
// Optional Wait-state timeout with error reporting: define UART_ARB_TIMEOUT_EN.
module uart_bus_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_rd_en,
  input  logic                  m0_wr_en,
  input  logic [2:0]            m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_rd_en,
  input  logic                  m1_wr_en,
  input  logic [2:0]            m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  s_rd_en,
  output logic                  s_wr_en,
  output logic [2:0]            s_addr,
  output logic [DATA_WIDTH-1:0] s_wr_data,
  input  logic [DATA_WIDTH-1:0] s_rd_data,
  input  logic                  s_ack,
  output logic                  busy,
  output logic [1:0]            grant_db
);

  localparam int unsigned AW    = 3;
  localparam int unsigned CNT_W = 16;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_gnt, w_gnt_nxt;
  logic                  r_last, w_last_nxt;
  logic                  r_op_rd, w_op_rd_nxt;
  logic                  r_s_rd_en, w_s_rd_en_nxt;
  logic                  r_s_wr_en, w_s_wr_en_nxt;
  logic [AW-1:0]         r_s_addr, w_s_addr_nxt;
  logic [DATA_WIDTH-1:0] r_s_wr_data, w_s_wr_data_nxt;
  logic                  r_m0_ack, w_m0_ack_nxt;
  logic                  r_m1_ack, w_m1_ack_nxt;
  logic [DATA_WIDTH-1:0] r_m0_rd_data, w_m0_rd_data_nxt;
  logic [DATA_WIDTH-1:0] r_m1_rd_data, w_m1_rd_data_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [1:0]            r_grant_db, w_grant_db_nxt;
  logic                  w_req0, w_req1, w_pick1, w_done, w_timeout;
`ifdef UART_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_m0_err, w_m0_err_nxt;
  logic                  r_m1_err, w_m1_err_nxt;
`endif

  assign w_req0  = m0_rd_en | m0_wr_en;
  assign w_req1  = m1_rd_en | m1_wr_en;
  // Master 1 wins when alone, or on a tie when master 0 was served last.
  assign w_pick1 = w_req1 & (~w_req0 | ~r_last);

  always_comb begin
    w_state_nxt      = r_state;
    w_gnt_nxt        = r_gnt;
    w_last_nxt       = r_last;
    w_op_rd_nxt      = r_op_rd;
    w_s_rd_en_nxt    = 1'b0;
    w_s_wr_en_nxt    = 1'b0;
    w_s_addr_nxt     = r_s_addr;
    w_s_wr_data_nxt  = r_s_wr_data;
    w_m0_ack_nxt     = 1'b0;
    w_m1_ack_nxt     = 1'b0;
    w_m0_rd_data_nxt = '0;
    w_m1_rd_data_nxt = '0;
    w_done           = 1'b0;
    w_timeout        = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    w_cnt_nxt        = r_cnt;
    w_m0_err_nxt     = 1'b0;
    w_m1_err_nxt     = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          w_state_nxt     = S_ISSUE;
          w_gnt_nxt       = w_pick1;
          w_op_rd_nxt     = w_pick1 ? m1_rd_en : m0_rd_en;
          w_s_rd_en_nxt   = w_op_rd_nxt;
          w_s_wr_en_nxt   = ~w_op_rd_nxt;
          w_s_addr_nxt    = w_pick1 ? m1_addr : m0_addr;
          w_s_wr_data_nxt = w_pick1 ? m1_wr_data : m0_wr_data;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
      end
      S_WAIT: begin
        if (s_ack) begin
          w_done = 1'b1;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_done    = 1'b1;
          w_timeout = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
        if (w_done) begin
          w_state_nxt     = S_DONE;
          w_s_addr_nxt    = '0;
          w_s_wr_data_nxt = '0;
          w_m0_ack_nxt    = ~r_gnt;
          w_m1_ack_nxt    = r_gnt;
          if (r_op_rd && !w_timeout) begin
            w_m0_rd_data_nxt = r_gnt ? '0 : s_rd_data;
            w_m1_rd_data_nxt = r_gnt ? s_rd_data : '0;
          end
`ifdef UART_ARB_TIMEOUT_EN
          w_m0_err_nxt = w_timeout & ~r_gnt;
          w_m1_err_nxt = w_timeout & r_gnt;
`endif
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_last_nxt  = r_gnt;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_grant_db_nxt = w_busy_nxt ? (w_gnt_nxt ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_gnt        <= 1'b0;
      r_last       <= 1'b1;
      r_op_rd      <= 1'b0;
      r_s_rd_en    <= 1'b0;
      r_s_wr_en    <= 1'b0;
      r_s_addr     <= '0;
      r_s_wr_data  <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rd_data <= '0;
      r_m1_rd_data <= '0;
      r_busy       <= 1'b0;
      r_grant_db   <= 2'b00;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt        <= '0;
      r_m0_err     <= 1'b0;
      r_m1_err     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_last       <= w_last_nxt;
      r_op_rd      <= w_op_rd_nxt;
      r_s_rd_en    <= w_s_rd_en_nxt;
      r_s_wr_en    <= w_s_wr_en_nxt;
      r_s_addr     <= w_s_addr_nxt;
      r_s_wr_data  <= w_s_wr_data_nxt;
      r_m0_ack     <= w_m0_ack_nxt;
      r_m1_ack     <= w_m1_ack_nxt;
      r_m0_rd_data <= w_m0_rd_data_nxt;
      r_m1_rd_data <= w_m1_rd_data_nxt;
      r_busy       <= w_busy_nxt;
      r_grant_db   <= w_grant_db_nxt;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt        <= w_cnt_nxt;
      r_m0_err     <= w_m0_err_nxt;
      r_m1_err     <= w_m1_err_nxt;
`endif
    end
  end

  assign s_rd_en    = r_s_rd_en;
  assign s_wr_en    = r_s_wr_en;
  assign s_addr     = r_s_addr;
  assign s_wr_data  = r_s_wr_data;
  assign m0_ack     = r_m0_ack;
  assign m1_ack     = r_m1_ack;
  assign m0_rd_data = r_m0_rd_data;
  assign m1_rd_data = r_m1_rd_data;
  assign busy       = r_busy;
  assign grant_db   = r_grant_db;
`ifdef UART_ARB_TIMEOUT_EN
  assign m0_err     = r_m0_err;
  assign m1_err     = r_m1_err;
`else
  assign m0_err     = 1'b0;
  assign m1_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter: transaction-level model of round-robin
// grants, op selection and completion data; honours UART_ARB_TIMEOUT_EN.
module tb_uart_bus_arbiter;
  localparam int unsigned DW = 32;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 256;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_rd_en = 0, m0_wr_en = 0, m1_rd_en = 0, m1_wr_en = 0;
  logic [2:0]    m0_addr = 0, m1_addr = 0;
  logic [DW-1:0] m0_wr_data = 0, m1_wr_data = 0;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic          s_rd_en, s_wr_en, busy;
  logic [2:0]    s_addr;
  logic [DW-1:0] s_wr_data;
  logic [DW-1:0] s_rd_data = 0;
  logic          s_ack = 0;
  logic [1:0]    grant_db;

  always #5 clk = ~clk;

  uart_bus_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_rd_data(m0_rd_data), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_rd_data(m1_rd_data), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_rd_en(s_rd_en), .s_wr_en(s_wr_en), .s_addr(s_addr), .s_wr_data(s_wr_data),
    .s_rd_data(s_rd_data), .s_ack(s_ack), .busy(busy), .grant_db(grant_db)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_last = 1;  // model: index of last-served master

  typedef struct {
    bit seen; int st_lat; logic rd; logic wr; logic [2:0] addr; logic [DW-1:0] wdata;
    logic [1:0] gnt; bit held; bit acked; int ack_lat; int who; logic err;
    logic [DW-1:0] data; logic other; bit pulse1;
  } obs_t;

  // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
  function automatic int model_pick(bit r0, bit r1, int last);
    if (r0 && r1) return (last == 1) ? 0 : 1;
    return r0 ? 0 : 1;
  endfunction

  function automatic logic [11:0] exp_iss(int m, bit rd, logic [2:0] addr);
    return {1'b1, 4'd1, rd, ~rd, addr, (m == 1) ? 2'b10 : 2'b01};
  endfunction

  function automatic logic [11:0] iss_vec(obs_t o);
    return {o.seen, 4'(o.st_lat), o.rd, o.wr, o.addr, o.gnt};
  endfunction

  function automatic logic [13:0] exp_done(int m, bit err, int lat);
    return {1'b1, 1'b1, 1'(m), err, 1'b0, 1'b1, 8'(lat)};
  endfunction

  function automatic logic [13:0] done_vec(obs_t o);
    return {o.held, o.acked, 1'(o.who), o.err, o.other, o.pulse1, 8'(o.ack_lat)};
  endfunction

  // UART responder plus observer for one transaction; drops the served master's request at its ack.
  task automatic serve(input int lat, input bit give_ack, input logic [DW-1:0] rdata, output obs_t o);
    o = '{default: 0};
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (s_rd_en || s_wr_en) begin o.seen = 1; o.st_lat = i; break; end
    end
    if (!o.seen) return;
    o.rd = s_rd_en; o.wr = s_wr_en; o.addr = s_addr; o.wdata = s_wr_data; o.gnt = grant_db;
    @(negedge clk);
    o.held = !s_rd_en && !s_wr_en && s_addr == o.addr && s_wr_data == o.wdata && busy && grant_db == o.gnt;
    repeat (lat - 1) @(negedge clk);
    if (give_ack) begin s_ack = 1'b1; s_rd_data = rdata; end
    for (int i = lat + 1; i <= lat + 60; i++) begin
      @(negedge clk);
      s_ack = 1'b0; s_rd_data = $urandom;
      if (m0_ack || m1_ack) begin
        o.acked = 1; o.ack_lat = i; o.who = m1_ack ? 1 : 0;
        o.err   = m1_ack ? m1_err : m0_err;
        o.data  = m1_ack ? m1_rd_data : m0_rd_data;
        o.other = m1_ack ? (m0_ack | m0_err | (|m0_rd_data)) : (m1_ack & m0_ack) | m1_err | (|m1_rd_data);
        if (m1_ack) begin m1_rd_en = 0; m1_wr_en = 0; end else begin m0_rd_en = 0; m0_wr_en = 0; end
        break;
      end
    end
    if (!o.acked) return;
    @(negedge clk);
    o.pulse1 = !m0_ack && !m1_ack && !busy && grant_db == 2'b00;
  endtask

  task automatic test_reset();
    logic [127:0] v;
    #2;
    v = {m0_rd_data, m1_rd_data, m0_ack, m1_ack, m0_err, m1_err, s_rd_en, s_wr_en, s_addr, s_wr_data, busy, grant_db};
    n_cmp++;
    if (v !== '0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", v); end
    repeat (3) @(negedge clk);
    v = {m0_rd_data, m1_rd_data, m0_ack, m1_ack, m0_err, m1_err, s_rd_en, s_wr_en, s_addr, s_wr_data, busy, grant_db};
    n_cmp++;
    if (v !== '0) begin n_bad++; $display("FAIL reset_held got %h want 0", v); end
    rst_n = 1'b1;
    m_last = 1;
  endtask

  task automatic test_single_read();
    obs_t o;
    m0_addr = 3'd3; m0_rd_en = 1;
    serve(3, 1, 32'h41, o);
    n_cmp++;
    if (iss_vec(o) !== exp_iss(0, 1, 3'd3)) begin n_bad++; $display("FAIL read_issue got %h want %h", iss_vec(o), exp_iss(0, 1, 3'd3)); end
    n_cmp++;
    if (done_vec(o) !== exp_done(0, 0, 4)) begin n_bad++; $display("FAIL read_done got %h want %h", done_vec(o), exp_done(0, 0, 4)); end
    n_cmp++;
    if (o.data !== 32'h41) begin n_bad++; $display("FAIL read_data got %h want 41", o.data); end
    m_last = 0;
  endtask

  task automatic test_tie_after_reset();
    obs_t o;
    logic [DW-1:0] wd [2];
    int w;
    wd[0] = 32'h11; wd[1] = 32'h22;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; m_last = 1;
    m0_addr = 3'd1; m0_wr_data = wd[0]; m0_wr_en = 1;
    m1_addr = 3'd2; m1_wr_data = wd[1]; m1_wr_en = 1;
    for (int t = 0; t < 2; t++) begin
      w = model_pick(m0_wr_en, m1_wr_en, m_last);
      serve(1 + t, 1, $urandom, o);
      n_cmp++;
      if (iss_vec(o) !== exp_iss(t, 0, 3'(t + 1))) begin n_bad++; $display("FAIL tie_issue%0d got %h want %h", t, iss_vec(o), exp_iss(t, 0, 3'(t + 1))); end
      n_cmp++;
      if (o.wdata !== wd[t] || w != t) begin n_bad++; $display("FAIL tie_wdata%0d got %h want %h (model pick %0d)", t, o.wdata, wd[t], w); end
      n_cmp++;
      if (done_vec(o) !== exp_done(t, 0, 2 + t) || o.data !== '0) begin n_bad++; $display("FAIL tie_done%0d got %h/%h want %h/0", t, done_vec(o), o.data, exp_done(t, 0, 2 + t)); end
      m_last = t;
    end
  endtask

  task automatic test_rd_wr_both();
    obs_t o;
    logic [DW-1:0] rd;
    rd = $urandom;
    m0_addr = 3'd0; m0_wr_data = $urandom; m0_rd_en = 1; m0_wr_en = 1;
    serve(2, 1, rd, o);
    n_cmp++;
    if (iss_vec(o) !== exp_iss(0, 1, 3'd0)) begin n_bad++; $display("FAIL rdwr_issue got %h want %h", iss_vec(o), exp_iss(0, 1, 3'd0)); end
    n_cmp++;
    if (done_vec(o) !== exp_done(0, 0, 3) || o.data !== rd) begin n_bad++; $display("FAIL rdwr_done got %h/%h want %h/%h", done_vec(o), o.data, exp_done(0, 0, 3), rd); end
    m_last = 0;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int seq [3];
    int w;
    logic [DW-1:0] rd;
    seq[0] = 1; seq[1] = 0; seq[2] = 1;
    m0_addr = 3'd5; m0_rd_en = 1; m1_addr = 3'd6; m1_rd_en = 1;
    for (int t = 0; t < 3; t++) begin
      w = model_pick(m0_rd_en, m1_rd_en, m_last);
      rd = $urandom;
      serve($urandom_range(1, 3), 1, rd, o);
      n_cmp++;
      if (o.who != seq[t] || iss_vec(o) !== exp_iss(w, 1, (w == 1) ? 3'd6 : 3'd5)) begin
        n_bad++; $display("FAIL b2b_grant%0d got m%0d/%h want m%0d/%h", t, o.who, iss_vec(o), seq[t], exp_iss(w, 1, (w == 1) ? 3'd6 : 3'd5));
      end
      n_cmp++;
      if (o.data !== rd || !o.acked || !o.pulse1 || o.other) begin n_bad++; $display("FAIL b2b_done%0d got %h want %h", t, o.data, rd); end
      m_last = w;
      if (t == 0) m1_rd_en = 1;
    end
  endtask

  task automatic test_random();
    bit act [2]; bit rdq [2]; logic [2:0] ad [2]; logic [DW-1:0] wdq [2];
    obs_t o; int r, w, lat; logic [DW-1:0] rd;
    for (int m = 0; m < 2; m++) act[m] = 0;
    for (int it = 0; it < 40; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (it < 24 && !act[m] && ($urandom_range(0, 1) == 1 || (m == 1 && !act[0]))) begin
          r = $urandom_range(1, 3);
          act[m] = 1; rdq[m] = r[0]; ad[m] = 3'($urandom); wdq[m] = $urandom;
          if (m == 0) begin m0_rd_en = r[0]; m0_wr_en = r[1]; m0_addr = ad[0]; m0_wr_data = wdq[0]; end
          else        begin m1_rd_en = r[0]; m1_wr_en = r[1]; m1_addr = ad[1]; m1_wr_data = wdq[1]; end
        end
      end
      if (!act[0] && !act[1]) break;
      w = model_pick(act[0], act[1], m_last);
      lat = $urandom_range(1, 5); rd = $urandom;
      serve(lat, 1, rd, o);
      n_cmp++;
      if (iss_vec(o) !== exp_iss(w, rdq[w], ad[w]) || (!rdq[w] && o.wdata !== wdq[w])) begin
        n_bad++; $display("FAIL rand_issue%0d got %h/%h want %h/%h", it, iss_vec(o), o.wdata, exp_iss(w, rdq[w], ad[w]), wdq[w]);
      end
      n_cmp++;
      if (done_vec(o) !== exp_done(w, 0, lat + 1)) begin n_bad++; $display("FAIL rand_done%0d got %h want %h", it, done_vec(o), exp_done(w, 0, lat + 1)); end
      n_cmp++;
      if (o.data !== (rdq[w] ? rd : '0)) begin n_bad++; $display("FAIL rand_data%0d got %h want %h", it, o.data, rdq[w] ? rd : '0); end
      act[w] = 0; m_last = w;
    end
  endtask

  task automatic test_wait_limit();
    obs_t o;
    logic [DW-1:0] rd;
    rd = $urandom;
`ifdef UART_ARB_TIMEOUT_EN
    m0_addr = 3'd2; m0_rd_en = 1;
    serve(1, 0, '0, o);
    n_cmp++;
    if (done_vec(o) !== exp_done(0, 1, 5) || o.data !== '0) begin n_bad++; $display("FAIL timeout_done got %h/%h want %h/0", done_vec(o), o.data, exp_done(0, 1, 5)); end
    m_last = 0;
    m1_addr = 3'd4; m1_rd_en = 1;
    serve(4, 1, rd, o);
    n_cmp++;
    if (done_vec(o) !== exp_done(1, 0, 5) || o.data !== rd) begin n_bad++; $display("FAIL ack_at_expiry got %h/%h want %h/%h", done_vec(o), o.data, exp_done(1, 0, 5), rd); end
    m_last = 1;
`else
    m0_addr = 3'd2; m0_rd_en = 1;
    serve(30, 1, rd, o);
    n_cmp++;
    if (done_vec(o) !== exp_done(0, 0, 31) || o.data !== rd) begin n_bad++; $display("FAIL long_wait got %h/%h want %h/%h", done_vec(o), o.data, exp_done(0, 0, 31), rd); end
    m_last = 0;
`endif
  endtask

  task automatic test_stray_ack();
    bit bad;
    bad = 0;
    s_ack = 1; s_rd_data = $urandom;
    @(negedge clk); s_ack = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy || m0_ack || m1_ack || m0_err || m1_err || s_rd_en || s_wr_en || (|m0_rd_data) || (|m1_rd_data)) bad = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL stray_ack got activity want none"); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit seen;
    logic [7:0] v;
    seen = 0;
    m0_addr = 3'd7; m0_wr_data = $urandom; m0_wr_en = 1;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = s_wr_en; end
    repeat (2) @(negedge clk);
    rst_n = 1'b0; #1;
    v = {busy, grant_db, m0_ack, m1_ack, s_rd_en, s_wr_en, |s_addr};
    n_cmp++;
    if (!seen || v !== 8'h00) begin n_bad++; $display("FAIL reset_mid got %h (strobe seen %0d) want 00", v, seen); end
    m0_wr_en = 0; m_last = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, m0_ack, m1_ack} !== 3'b000) begin n_bad++; $display("FAIL reset_mid_idle got %b want 000", {busy, m0_ack, m1_ack}); end
    m0_addr = 3'd1; m0_rd_en = 1; m1_addr = 3'd6; m1_rd_en = 1;
    for (int t = 0; t < 2; t++) begin
      serve(2, 1, 32'hA5A5_0000 + 32'(t), o);
      n_cmp++;
      if (iss_vec(o) !== exp_iss(t, 1, (t == 1) ? 3'd6 : 3'd1) || done_vec(o) !== exp_done(t, 0, 3) || o.data !== 32'hA5A5_0000 + 32'(t)) begin
        n_bad++; $display("FAIL after_reset%0d got %h/%h/%h want m%0d", t, iss_vec(o), done_vec(o), o.data, t);
      end
      m_last = t;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie_after_reset();
    test_rd_wr_both();
    test_back_to_back();
    test_random();
    test_wait_limit();
    test_stray_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
